// File: rtl/barrel_arbiter.sv
// -----------------------------------------------------------------------------
// barrel_arbiter
//
// Round-robin arbiter that lets NUM_REQ requesters share a single barrel
// rotator. One job is in flight at a time: the granted requester's vector and
// rotate amount are latched, handed to the rotator, and the rotator's result
// is returned verbatim to that requester only.
//
// Ports
//   clk, rst     : clock (rising edge) and synchronous active-high reset
//   req_valid    : per-requester job pending
//   req_data     : packed operand vectors, requester r at slice r
//   req_rot      : packed rotate amounts, requester r at slice r
//   req_rdy      : one-hot, combinational accept pulse (IDLE only)
//   rsp_valid    : one-hot, result available for the granted requester
//   rsp_data     : captured rotator result, shared by all requesters
//   rsp_ack      : per-requester result consume
//   bar_ip/rot   : operands to the rotator (held constant while stalled)
//   bar_start    : operands valid to the rotator
//   bar_rdy      : rotator accepts operands
//   bar_op       : rotator result
//   bar_valid    : rotator result valid
//   bar_ack      : arbiter ready for the rotator result
//   busy         : high whenever a job is in flight
//   done_cnt     : completed-job counter, wraps
// -----------------------------------------------------------------------------
module barrel_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int NUM_ELEMS  = 32,
   parameter int DATA_WIDTH = 8,
   parameter int ROT_WIDTH  = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [NUM_REQ-1:0]                        req_valid,
   input  logic [NUM_REQ*NUM_ELEMS*DATA_WIDTH-1:0]   req_data,
   input  logic [NUM_REQ*ROT_WIDTH-1:0]              req_rot,
   output logic [NUM_REQ-1:0]                        req_rdy,
   output logic [NUM_REQ-1:0]                        rsp_valid,
   output logic [NUM_ELEMS*DATA_WIDTH-1:0]           rsp_data,
   input  logic [NUM_REQ-1:0]                        rsp_ack,
   output logic [NUM_ELEMS*DATA_WIDTH-1:0]           bar_ip,
   output logic [ROT_WIDTH-1:0]                      bar_rot,
   output logic                                      bar_start,
   input  logic                                      bar_rdy,
   input  logic [NUM_ELEMS*DATA_WIDTH-1:0]           bar_op,
   input  logic                                      bar_valid,
   output logic                                      bar_ack,
   output logic                                      busy,
   output logic [CNT_WIDTH-1:0]                      done_cnt
);

   localparam int VEC_W = NUM_ELEMS * DATA_WIDTH;
   localparam int PTR_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next;

   logic [PTR_W-1:0]      r_ptr;
   logic [PTR_W-1:0]      r_gnt;
   logic [VEC_W-1:0]      r_hold_data;
   logic [ROT_WIDTH-1:0]  r_hold_rot;
   logic [VEC_W-1:0]      r_rsp;
   logic [CNT_WIDTH-1:0]  r_cnt;

   logic                  w_found;
   logic [PTR_W-1:0]      w_gnt;
   logic [PTR_W-1:0]      w_idx;
   logic [NUM_REQ-1:0]    w_gnt_oh;
   logic [NUM_REQ-1:0]    w_held_oh;
   logic                  w_accept;
   logic                  w_capture;
   logic                  w_done;

   // Round-robin search: start just after the last served requester and wrap,
   // so the most recently served requester has the lowest priority.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_idx = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_gnt   = w_idx;
         end
      end
   end

   assign w_gnt_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt;
   assign w_held_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      req_rdy   = '0;
      rsp_valid = '0;
      bar_start = 1'b0;
      bar_ack   = 1'b0;
      w_accept  = 1'b0;
      w_capture = 1'b0;
      w_done    = 1'b0;
      case (r_state)
         S_IDLE: begin
            // No accept pulse while reset is being applied; the edge would
            // discard the grant anyway.
            if (w_found && !rst) begin
               req_rdy  = w_gnt_oh;
               w_accept = 1'b1;
               w_next   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            bar_start = 1'b1;
            if (bar_rdy) begin
               w_next = S_WAIT;
            end
         end
         S_WAIT: begin
            bar_ack = 1'b1;
            if (bar_valid) begin
               w_capture = 1'b1;
               w_next    = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid = w_held_oh;
            // Only the granted requester's ack retires the job.
            if (rsp_ack[r_gnt]) begin
               w_done = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= PTR_W'(NUM_REQ - 1);
         r_gnt       <= '0;
         r_hold_data <= '0;
         r_hold_rot  <= '0;
         r_rsp       <= '0;
         r_cnt       <= '0;
      end else begin
         if (w_accept) begin
            r_gnt       <= w_gnt;
            r_hold_data <= req_data[int'(w_gnt)*VEC_W +: VEC_W];
            r_hold_rot  <= req_rot[int'(w_gnt)*ROT_WIDTH +: ROT_WIDTH];
         end
         if (w_capture) begin
            r_rsp <= bar_op;
         end
         if (w_done) begin
            r_ptr <= r_gnt;
            r_cnt <= r_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign bar_ip   = r_hold_data;
   assign bar_rot  = r_hold_rot;
   assign rsp_data = r_rsp;
   assign busy     = (r_state != S_IDLE);
   assign done_cnt = r_cnt;

endmodule
